// File: rtl/video_pkg.sv
// Shared definitions for the RGB video path: pixel width, default raster
// geometry and the source-arbiter state encoding.
package video_pkg;

  localparam int DEF_DATA_W      = 24;
  localparam int DEF_LINE_PIX    = 1280;
  localparam int DEF_FRAME_LINES = 720;
  localparam int DEF_FRAME_CNT_W = 16;

  typedef enum logic {
    SEEK = 1'b0,
    PASS = 1'b1
  } arb_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_video_reg_slice.sv
// Single-stage registered AXI4-Stream slice for video beats (tdata/tuser/tlast).
// The upstream side may push whenever the register is empty or being drained.
module axis_video_reg_slice #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tuser,
  input  logic              s_tlast,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tuser,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready
);

  assign s_tready = !m_tvalid || m_tready;

  // Capture a new beat when the register is free; otherwise hold it stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tdata  <= '0;
      m_tuser  <= 1'b0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
    end else if (s_tready) begin
      m_tvalid <= s_tvalid;
      if (s_tvalid) begin
        m_tdata <= s_tdata;
        m_tuser <= s_tuser;
        m_tlast <= s_tlast;
      end
    end
  end

endmodule

// File: rtl/video_src_arbiter.sv
// Two-source AXI4-Stream RGB video arbiter. Forwards one source through a
// register slice, switches only at frame end, drains the idle source and
// tracks raster position, completed frames and framing errors.
module video_src_arbiter
  import video_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LINE_PIX    = DEF_LINE_PIX,
  parameter int FRAME_LINES = DEF_FRAME_LINES,
  parameter int FRAME_CNT_W = DEF_FRAME_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sel_req,
  input  logic                   err_clr,
  input  logic [DATA_W-1:0]      s0_axis_video_tdata,
  input  logic                   s0_axis_video_tvalid,
  input  logic                   s0_axis_video_tuser,
  input  logic                   s0_axis_video_tlast,
  output logic                   s0_axis_video_tready,
  input  logic [DATA_W-1:0]      s1_axis_video_tdata,
  input  logic                   s1_axis_video_tvalid,
  input  logic                   s1_axis_video_tuser,
  input  logic                   s1_axis_video_tlast,
  output logic                   s1_axis_video_tready,
  input  logic                   m_axis_video_tready,
  output logic [DATA_W-1:0]      m_axis_video_tdata,
  output logic                   m_axis_video_tvalid,
  output logic                   m_axis_video_tuser,
  output logic                   m_axis_video_tlast,
  output logic                   active_src,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   sof_err,
  output logic                   eol_err
);

  localparam int PIX_W  = cnt_width(LINE_PIX);
  localparam int LINE_W = cnt_width(FRAME_LINES);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_PIX - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);

  arb_state_e        state, state_nxt;
  logic [PIX_W-1:0]  pix_cnt, pix_nxt, pix_base;
  logic [LINE_W-1:0] line_cnt, line_nxt, line_base;
  logic [DATA_W-1:0] act_tdata;
  logic              act_tvalid, act_tuser, act_tlast;
  logic              slice_ready, accept, load_en;
  logic              sof_hit, eol_hit, frame_end, switch_src;

  // Route the currently selected source onto the internal beat bus.
  always_comb begin
    act_tdata  = active_src ? s1_axis_video_tdata  : s0_axis_video_tdata;
    act_tvalid = active_src ? s1_axis_video_tvalid : s0_axis_video_tvalid;
    act_tuser  = active_src ? s1_axis_video_tuser  : s0_axis_video_tuser;
    act_tlast  = active_src ? s1_axis_video_tlast  : s0_axis_video_tlast;
  end

  assign accept     = act_tvalid && slice_ready;
  assign switch_src = frame_end && (sel_req != active_src);

  // Work out raster position and error flags for a loaded beat; a tuser beat
  // always restarts the raster at pixel 0 of line 0 before tlast is applied.
  always_comb begin
    sof_hit   = 1'b0;
    eol_hit   = 1'b0;
    frame_end = 1'b0;
    pix_base  = pix_cnt;
    line_base = line_cnt;
    pix_nxt   = pix_cnt;
    line_nxt  = line_cnt;
    if (load_en) begin
      if (act_tuser) begin
        sof_hit   = (state == PASS) && ((pix_cnt != '0) || (line_cnt != '0));
        pix_base  = '0;
        line_base = '0;
      end
      if (act_tlast) begin
        eol_hit = (pix_base != PIX_LAST);
        pix_nxt = '0;
        if (line_base == LINE_LAST) begin
          frame_end = 1'b1;
          line_nxt  = '0;
        end else begin
          line_nxt = line_base + LINE_W'(1);
        end
      end else begin
        line_nxt = line_base;
        if (pix_base == PIX_LAST) begin
          eol_hit = 1'b1;
          pix_nxt = pix_base;
        end else begin
          pix_nxt = pix_base + PIX_W'(1);
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEEK;
    else     state <= state_nxt;
  end

  // Next state: lock on at a start of frame, fall back to seeking on a switch.
  always_comb begin
    state_nxt = state;
    case (state)
      SEEK:    if (load_en) state_nxt = PASS;
      PASS:    state_nxt = PASS;
      default: state_nxt = SEEK;
    endcase
    if (switch_src) state_nxt = SEEK;
  end

  // Outputs: what gets loaded into the slice and which source sees backpressure.
  always_comb begin
    load_en = 1'b0;
    case (state)
      SEEK:    load_en = accept && act_tuser;
      PASS:    load_en = accept;
      default: load_en = 1'b0;
    endcase
    s0_axis_video_tready = active_src ? 1'b1 : slice_ready;
    s1_axis_video_tready = active_src ? slice_ready : 1'b1;
  end

  // Raster counters, frame counter, source selection and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt    <= '0;
      line_cnt   <= '0;
      frame_cnt  <= '0;
      active_src <= 1'b0;
      sof_err    <= 1'b0;
      eol_err    <= 1'b0;
    end else begin
      pix_cnt  <= pix_nxt;
      line_cnt <= line_nxt;
      if (frame_end) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      if (switch_src) active_src <= sel_req;
      sof_err <= sof_hit || (sof_err && !err_clr);
      eol_err <= eol_hit || (eol_err && !err_clr);
    end
  end

  axis_video_reg_slice #(
    .DATA_W (DATA_W)
  ) u_out_slice (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (act_tdata),
    .s_tuser  (act_tuser),
    .s_tlast  (act_tlast),
    .s_tvalid (load_en),
    .s_tready (slice_ready),
    .m_tdata  (m_axis_video_tdata),
    .m_tuser  (m_axis_video_tuser),
    .m_tlast  (m_axis_video_tlast),
    .m_tvalid (m_axis_video_tvalid),
    .m_tready (m_axis_video_tready)
  );

endmodule

// File: doc/video_src_arbiter.md
Name: video_src_arbiter

Overview:
- Two-source AXI4-Stream video arbiter feeding the 24-bit RGB video path (ahead of the HDMI/VDMA output chain).
- Selects one of two 24-bit RGB video streams and forwards it through a registered output stage with full valid/ready backpressure.
- Switches sources only on frame boundaries; the unselected source is drained.
- Tracks line/pixel position, counts frames and flags framing errors.

Parameters:
- DATA_W, 24, pixel width (8b R,G,B packed).
- LINE_PIX, 1280, pixels per line (tlast expected on beat LINE_PIX-1).
- FRAME_LINES, 720, lines per frame.
- FRAME_CNT_W, 16, width of frame counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-high.
- sel_req  in  1  requested source (0 = s0, 1 = s1), level, sampled only at frame end.
- err_clr  in  1  one-cycle pulse, clears sticky errors.
- s0_axis_video_tdata/tvalid/tuser/tlast  in  DATA_W/1/1/1  source 0 stream.
- s0_axis_video_tready  out  1  source 0 ready.
- s1_axis_video_tdata/tvalid/tuser/tlast  in  DATA_W/1/1/1  source 1 stream.
- s1_axis_video_tready  out  1  source 1 ready.
- m_axis_video_tready  in  1  downstream ready.
- m_axis_video_tdata/tvalid/tuser/tlast  out  DATA_W/1/1/1  output stream.
- active_src  out  1  currently forwarded source.
- frame_cnt  out  FRAME_CNT_W  completed frames forwarded, wraps.
- sof_err  out  1  sticky: tuser seen mid-frame.
- eol_err  out  1  sticky: tlast at wrong pixel, or missing at LINE_PIX-1.

Behaviour:
Reset (rst=1, async):
- m_axis_video_tvalid/tuser/tlast = 0, tdata = 0.
- state = SEEK, active_src = 0.
- pix_cnt = 0, line_cnt = 0, frame_cnt = 0, errors = 0.
- rst mid-frame aborts immediately; any held output beat is lost.

Output stage (one register slice):
- Load when (!m_tvalid | m_tready); hold data/flags stable while m_tvalid & !m_tready.
- Latency: 1 clk from accepted input beat to m_tvalid.

Ready mapping:
- Active source tready = (!m_tvalid | m_tready) in all states.
- Inactive source tready = 1 always (beats discarded).
- A beat is accepted on the active source when tvalid & tready.

FSM:
- SEEK
  - Accepted active beats with tuser=0 are discarded (not loaded).
  - Accepted beat with tuser=1 is loaded; pix_cnt = 1 (or 0 with line_cnt+1 if tlast); goto PASS.
- PASS: every accepted beat is loaded. Counter updates per accepted beat:
  - tlast=0 and pix_cnt=LINE_PIX-1: set eol_err; pix_cnt keeps counting to tlast (saturate at LINE_PIX-1).
  - tlast=1 and pix_cnt!=LINE_PIX-1: set eol_err; treat as end of line anyway.
  - End of line: pix_cnt=0, line_cnt+1.
  - End of line with line_cnt=FRAME_LINES-1 (frame end): line_cnt=0, frame_cnt+1 (wrap).
    - If sel_req != active_src: active_src <= sel_req, goto SEEK.
    - Else stay in PASS.
  - tuser=1 while (pix_cnt!=0 | line_cnt!=0): set sof_err; resync with pix_cnt=1, line_cnt=0; the beat is forwarded.
  - tuser=1 at pix_cnt=0, line_cnt=0 is normal.

Boundary cases:
- sel_req toggling mid-frame has no effect; only its value at the frame-end beat counts.
- Switch happens even if the output register is stalled; the stalled beat completes first, and the new source is not accepted until the slice frees.
- err_clr in the same cycle as a new error: the error wins (stays 1).
- Counters only advance on accepted beats; backpressure never drops or duplicates beats.
- tuser and tlast on the same beat: SOF processing first, then end of line.

Decomposition:
- Shared package video_pkg: DATA_W, LINE_PIX/FRAME_LINES defaults, FSM state encoding (SEEK, PASS).
- Sub-module axis_video_reg_slice: single-stage registered AXIS slice (tdata/tuser/tlast, valid/ready). Reused elsewhere in the video path.

Test Plan:
- Reset, s0 sends 2 frames (LINE_PIX=4, FRAME_LINES=2 overrides), m_tready=1 -> 16 beats out with 1-clk latency, tuser only on beats 0 and 8, frame_cnt=2, no errors.
- s0 frame runs with sel_req=1 raised mid-frame -> s0 frame completes intact, then active_src=1; s1 beats before its tuser are dropped (s1_tready=1); first output beat after the switch has tuser=1.
- m_tready pattern 1,0,0,1 during the frame -> m_tdata held stable while stalled; active tready=0 only while m_tvalid & !m_tready; all 8 beats delivered in order.
- tuser injected on pixel 2 of line 1 -> sof_err=1, line_cnt resync to 0, frame_cnt not incremented for the aborted frame; err_clr -> sof_err=0.
- tlast on pixel 2 (LINE_PIX=4) -> eol_err=1, next beat counted as pixel 0 of the next line.
- rst asserted mid-line with m_tvalid=1 -> outputs 0 asynchronously, state SEEK, counters 0; after rst the block waits for the next s0 tuser.
